// File: rtl/fft_stage_sequencer.sv
// Radix-2 DIT FFT stage sequencer: walks log2(N) stages, issues one butterfly job per
// accepted handshake, and drains outstanding jobs at each stage boundary.
module fft_stage_sequencer #(
  parameter int ADDR_W  = 12,
  parameter int MAX_OUT = 4,
  parameter int OUT_W   = 3
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_DATA_LOADED,
  input  logic [ADDR_W-1:0] i_SAMPLES_NUMBER,
  output logic              o_BFLY_VALID,
  input  logic              i_BFLY_READY,
  output logic [ADDR_W-1:0] o_BFLY_IDX_A,
  output logic [ADDR_W-1:0] o_BFLY_IDX_B,
  output logic [ADDR_W-2:0] o_TW_IDX,
  input  logic              i_BFLY_DONE,
  output logic [3:0]        o_STAGE,
  output logic              o_BUSY,
  output logic              o_CALC_END,
  output logic              o_ERR
);

  localparam int PW = ADDR_W - 1;
  localparam logic [OUT_W-1:0] MAX_CNT = OUT_W'(MAX_OUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE,
    S_ERROR
  } state_t;

  state_t            state, state_nxt;
  logic [PW-1:0]     half_n_q, half_n_nxt;
  logic [3:0]        l_q, l_nxt;
  logic [3:0]        stage_q, stage_nxt;
  logic [PW-1:0]     pair_q, pair_nxt;
  logic [OUT_W-1:0]  out_q, out_nxt;
  logic              err_q, err_nxt;

  logic              n_legal;
  logic [3:0]        n_log2;
  logic              issuing;
  logic              accept;
  logic              done_ok;
  logic              done_bad;
  logic [PW-1:0]     last_pair;
  logic [PW-1:0]     half;
  logic [PW-1:0]     j;
  logic [3:0]        tw_shift;
  logic [ADDR_W-1:0] idx_a;

  // N must be one-hot and at least 4.
  assign n_legal = (i_SAMPLES_NUMBER != '0)
                && ((i_SAMPLES_NUMBER & (i_SAMPLES_NUMBER - ADDR_W'(1))) == '0)
                && (i_SAMPLES_NUMBER[1:0] == 2'b00);

  always_comb begin
    n_log2 = '0;
    for (int i = 0; i < ADDR_W; i++) begin
      if (i_SAMPLES_NUMBER[i]) n_log2 = 4'(i);
    end
  end

  assign issuing   = (state == S_ISSUE);
  assign accept    = o_BFLY_VALID & i_BFLY_READY;
  assign done_ok   = i_BFLY_DONE & (out_q != '0);
  assign done_bad  = i_BFLY_DONE & (out_q == '0);
  assign last_pair = half_n_q - PW'(1);

  // Butterfly indices: A has a 0 inserted at bit s, B sets it; twiddle scales j to W_N.
  assign half     = PW'(1) << stage_q;
  assign j        = pair_q & (half - PW'(1));
  assign idx_a    = ((ADDR_W'(pair_q) >> stage_q) << (stage_q + 4'd1)) | ADDR_W'(j);
  assign tw_shift = l_q - 4'd1 - stage_q;

  assign o_BFLY_VALID = issuing && (out_q < MAX_CNT);
  assign o_BFLY_IDX_A = issuing ? idx_a : '0;
  assign o_BFLY_IDX_B = issuing ? (idx_a | ADDR_W'(half)) : '0;
  assign o_TW_IDX     = issuing ? (j << tw_shift) : '0;
  assign o_STAGE      = stage_q;
  assign o_BUSY       = issuing || (state == S_DRAIN);
  assign o_CALC_END   = (state == S_DONE);
  assign o_ERR        = err_q;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_nxt  = state;
    half_n_nxt = half_n_q;
    l_nxt      = l_q;
    stage_nxt  = stage_q;
    pair_nxt   = pair_q;
    err_nxt    = err_q | done_bad;
    out_nxt    = out_q;

    if (accept && !done_ok)      out_nxt = out_q + OUT_W'(1);
    else if (!accept && done_ok) out_nxt = out_q - OUT_W'(1);

    unique case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (i_DATA_LOADED) begin
          if (n_legal) begin
            state_nxt  = S_ISSUE;
            half_n_nxt = i_SAMPLES_NUMBER[ADDR_W-1:1];
            l_nxt      = n_log2;
            stage_nxt  = '0;
            pair_nxt   = '0;
            if (state == S_ERROR) err_nxt = 1'b0;
          end else begin
            state_nxt = S_ERROR;
            stage_nxt = '0;
            err_nxt   = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (accept) begin
          pair_nxt = pair_q + PW'(1);
          if (pair_q == last_pair) state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Next stage reads results of this one, so wait for every write-back.
        if (out_nxt == '0) begin
          if (stage_q < l_q - 4'd1) begin
            stage_nxt = stage_q + 4'd1;
            pair_nxt  = '0;
            state_nxt = S_ISSUE;
          end else begin
            state_nxt = S_DONE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state    <= S_IDLE;
      half_n_q <= '0;
      l_q      <= '0;
      stage_q  <= '0;
      pair_q   <= '0;
      out_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      half_n_q <= half_n_nxt;
      l_q      <= l_nxt;
      stage_q  <= stage_nxt;
      pair_q   <= pair_nxt;
      out_q    <= out_nxt;
      err_q    <= err_nxt;
    end
  end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Self-checking bench for fft_stage_sequencer: a job-list reference model built from the
// butterfly index formulas, a delayed-DONE engine model and random backpressure.
module tb_fft_stage_sequencer;

  localparam int ADDR_W = 12;

  typedef struct {
    int a;
    int b;
    int tw;
    int s;
  } job_t;

  logic clk = 1'b0;
  logic rstn;
  logic start, ready, done, sel;
  logic [ADDR_W-1:0] n_samples;

  logic start0, start1, done0, done1;
  logic valid0, valid1, busy0, busy1, end0, end1, err0, err1;
  logic [ADDR_W-1:0] a0, a1, b0, b1;
  logic [ADDR_W-2:0] tw0, tw1;
  logic [3:0] st0, st1;

  logic              o_valid, o_busy, o_calc_end, o_err;
  logic [ADDR_W-1:0] o_idx_a, o_idx_b;
  logic [ADDR_W-2:0] o_tw;
  logic [3:0]        o_stage;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // sel routes start/done to the MAX_OUT=1 instance and selects whose outputs are observed.
  assign start0 = start & ~sel;
  assign start1 = start & sel;
  assign done0  = done & ~sel;
  assign done1  = done & sel;

  assign o_valid    = sel ? valid1 : valid0;
  assign o_busy     = sel ? busy1  : busy0;
  assign o_calc_end = sel ? end1   : end0;
  assign o_err      = sel ? err1   : err0;
  assign o_idx_a    = sel ? a1     : a0;
  assign o_idx_b    = sel ? b1     : b0;
  assign o_tw       = sel ? tw1    : tw0;
  assign o_stage    = sel ? st1    : st0;

  fft_stage_sequencer #(.ADDR_W(ADDR_W), .MAX_OUT(4), .OUT_W(3)) dut (
    .i_clk            (clk),
    .i_rstn           (rstn),
    .i_DATA_LOADED    (start0),
    .i_SAMPLES_NUMBER (n_samples),
    .o_BFLY_VALID     (valid0),
    .i_BFLY_READY     (ready),
    .o_BFLY_IDX_A     (a0),
    .o_BFLY_IDX_B     (b0),
    .o_TW_IDX         (tw0),
    .i_BFLY_DONE      (done0),
    .o_STAGE          (st0),
    .o_BUSY           (busy0),
    .o_CALC_END       (end0),
    .o_ERR            (err0)
  );

  fft_stage_sequencer #(.ADDR_W(ADDR_W), .MAX_OUT(1), .OUT_W(1)) dut_one (
    .i_clk            (clk),
    .i_rstn           (rstn),
    .i_DATA_LOADED    (start1),
    .i_SAMPLES_NUMBER (n_samples),
    .o_BFLY_VALID     (valid1),
    .i_BFLY_READY     (ready),
    .o_BFLY_IDX_A     (a1),
    .o_BFLY_IDX_B     (b1),
    .o_TW_IDX         (tw1),
    .i_BFLY_DONE      (done1),
    .o_STAGE          (st1),
    .o_BUSY           (busy1),
    .o_CALC_END       (end1),
    .o_ERR            (err1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".valid"}, o_valid, 0);
    check({tag, ".idx_a"}, o_idx_a, 0);
    check({tag, ".idx_b"}, o_idx_b, 0);
    check({tag, ".tw"}, o_tw, 0);
    check({tag, ".stage"}, o_stage, 0);
    check({tag, ".busy"}, o_busy, 0);
    check({tag, ".calc_end"}, o_calc_end, 0);
    check({tag, ".err"}, o_err, 0);
  endtask

  // Runs one transform against the reference job list. Engine returns DONE exactly
  // 'delay' cycles after each accept. abort_after>0 stops after that many accepts.
  task automatic run_fft(input int n, input int max_out, input int delay,
                         input bit rand_ready, input int abort_after);
    job_t jobs[$];
    job_t jb;
    int   due[$];
    int   l, half, outst, cyc, cur_s, accepted, budget;
    bit   exp_valid, rdy, acc, dn, finished, all_done;

    l = $clog2(n);
    for (int s = 0; s < l; s++) begin
      half = 2 ** s;
      for (int p = 0; p < n / 2; p++) begin
        jb.a  = (p / half) * 2 * half + p % half;
        jb.b  = jb.a + half;
        jb.tw = (p % half) * (n / (2 * half));
        jb.s  = s;
        jobs.push_back(jb);
      end
    end
    outst = 0; cyc = 0; cur_s = -1; accepted = 0; finished = 1'b0;
    budget = 8 * n * l + 100;

    @(negedge clk);
    n_samples = ADDR_W'(n);
    start = 1'b1; ready = 1'b0; done = 1'b0;
    check("start.busy", o_busy, 0);
    @(negedge clk);
    start = 1'b0;

    while (cyc < budget) begin
      exp_valid = 1'b0;
      if (jobs.size() > 0 && outst < max_out)
        exp_valid = (jobs[0].s == cur_s) || (outst == 0);
      all_done = (jobs.size() == 0) && (outst == 0);
      check("valid", o_valid, exp_valid);
      check("busy", o_busy, !all_done);
      check("calc_end", o_calc_end, all_done);
      check("err", o_err, 0);
      if (exp_valid) begin
        check("idx_a", o_idx_a, jobs[0].a);
        check("idx_b", o_idx_b, jobs[0].b);
        check("tw", o_tw, jobs[0].tw);
        check("stage", o_stage, jobs[0].s);
      end
      if (all_done || (abort_after > 0 && accepted == abort_after)) begin
        finished = 1'b1;
        break;
      end

      rdy   = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      ready = rdy;
      start = rand_ready && ($urandom_range(0, 7) == 0);
      if (start) n_samples = ADDR_W'($urandom);
      acc = exp_valid && rdy;
      dn  = 1'b0;
      if (due.size() > 0) begin
        if (due[0] == cyc) begin
          dn = 1'b1;
          void'(due.pop_front());
        end
      end
      done = dn;
      if (acc) begin
        cur_s = jobs[0].s;
        void'(jobs.pop_front());
        outst++;
        accepted++;
        due.push_back(cyc + delay);
      end
      if (dn) outst--;
      cyc++;
      @(negedge clk);
    end
    start = 1'b0; ready = 1'b0; done = 1'b0;
    check("finished", finished, 1);

    if (abort_after == 0) begin
      check("job_count", accepted, (n / 2) * l);
      @(negedge clk);
      check("end_hold", o_calc_end, 1);
      check("end_hold.valid", o_valid, 0);
    end
  endtask

  initial begin
    rstn = 1'b0;
    sel = 1'b0; start = 1'b0; ready = 1'b0; done = 1'b0;
    n_samples = '0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rstn = 1'b1;

    // Reference transform, then backpressure, with the same-cycle accept/DONE steady state.
    run_fft(8, 4, 2, 1'b0, 0);
    run_fft(8, 4, 2, 1'b1, 0);
    run_fft(16, 4, 2, 1'b0, 0);
    run_fft(16, 4, 3, 1'b1, 0);

    // Single-outstanding engine.
    sel = 1'b1;
    run_fft(4, 1, 5, 1'b0, 0);
    run_fft(8, 1, 2, 1'b1, 0);
    sel = 1'b0;

    // Illegal N from DONE, then a legal restart clears the error.
    @(negedge clk);
    n_samples = ADDR_W'(12);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("bad_n.err", o_err, 1);
    check("bad_n.valid", o_valid, 0);
    check("bad_n.busy", o_busy, 0);
    check("bad_n.calc_end", o_calc_end, 0);
    repeat (3) @(negedge clk);
    check("bad_n.hold_valid", o_valid, 0);
    check("bad_n.hold_err", o_err, 1);
    run_fft(16, 4, 2, 1'b0, 0);

    // Reset mid-transform aborts asynchronously; next start begins from stage 0, pair 0.
    run_fft(16, 4, 2, 1'b0, 3);
    #2 rstn = 1'b0;
    #1 check_idle("async_rst");
    @(negedge clk);
    rstn = 1'b1;
    run_fft(16, 4, 3, 1'b1, 0);

    run_fft(256, 4, int'($urandom_range(1, 6)), 1'b1, 0);
    run_fft(2048, 4, 1, 1'b0, 0);

    // N below the minimum.
    @(negedge clk);
    n_samples = ADDR_W'(2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("n2.err", o_err, 1);
    check("n2.valid", o_valid, 0);

    // Spurious DONE while idle.
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    check("pre_spur.err", o_err, 0);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    check("spur.err", o_err, 1);
    check("spur.busy", o_busy, 0);
    check("spur.valid", o_valid, 0);
    @(negedge clk);
    check("spur.sticky", o_err, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
